// File: rtl/i2c_codec_wr_master.sv
// I2C write master for the CODEC configuration path.
// One wrt pulse -> START, {addr+W, cmd[15:8], cmd[7:0]} MSB first with ACK
// checks after every byte, then STOP and a one-cycle done pulse.
// SCL is push-pull; SDA is open-drain (drives 0 or releases).
// SCL/SDA/done are registered: the next-state logic decides the bus levels
// for the state/quarter being entered, so they change exactly at quarter edges.
module i2c_codec_wr_master #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         QTR      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data16,
    input  logic        wrt,
    output logic        done,
    output logic        err,
    output logic        SCL,
    inout  wire         SDA
);

    localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;
    localparam logic [QW-1:0] QMAX = QW'(QTR - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT   = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state, nxt_state;
    logic [QW-1:0] r_qcnt, nxt_qcnt;
    logic [2:0]    r_qi, nxt_qi;        // quarter index inside the current state/slot
    logic [3:0]    r_bit, nxt_bit;      // 0..7 data slots, 8 = ACK slot
    logic [1:0]    r_byte, nxt_byte;
    logic [23:0]   r_shift, nxt_shift;
    logic          r_err, nxt_err;
    logic          r_scl, nxt_scl;
    logic          r_sda_low, nxt_sda_low;
    logic          r_done, nxt_done;
    logic          w_tick;
    logic          w_sda_in;

    // SCL level for a given state and quarter
    function automatic logic f_scl(input state_t s, input logic [2:0] q);
        logic v;
        case (s)
            S_BIT:   v = (q >= 3'd2);
            S_STOP:  v = (q >= 3'd2);
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    // Whether SDA is pulled low for a given state, quarter, bit slot and data MSB
    function automatic logic f_sda_low(input state_t s, input logic [2:0] q,
                                       input logic [3:0] b, input logic msb);
        logic v;
        case (s)
            S_START: v = 1'b1;
            S_BIT:   v = (b == 4'd8) ? 1'b0 : ~msb;
            S_STOP:  v = (q != 3'd4);
            default: v = 1'b0;
        endcase
        return v;
    endfunction

    assign w_tick   = (r_qcnt == QMAX);
    assign w_sda_in = SDA;
    assign SDA      = r_sda_low ? 1'b0 : 1'bz;
    assign SCL      = r_scl;
    assign done     = r_done;
    assign err      = r_err;

    // Next-state, quarter timing, shift/ACK bookkeeping and next bus levels
    always_comb begin
        nxt_state = r_state;
        nxt_qcnt  = w_tick ? '0 : r_qcnt + QW'(1);
        nxt_qi    = w_tick ? r_qi + 3'd1 : r_qi;
        nxt_bit   = r_bit;
        nxt_byte  = r_byte;
        nxt_shift = r_shift;
        nxt_err   = r_err;
        case (r_state)
            S_IDLE: begin
                nxt_qcnt = '0;
                nxt_qi   = 3'd0;
                if (wrt) begin
                    nxt_state = S_START;
                    nxt_shift = {DEV_ADDR, 1'b0, data16};
                    nxt_err   = 1'b0;
                    nxt_bit   = 4'd0;
                    nxt_byte  = 2'd0;
                end else begin
                    nxt_state = S_IDLE;
                end
            end
            S_START: begin
                if (w_tick && (r_qi == 3'd1)) begin
                    nxt_state = S_BIT;
                    nxt_qi    = 3'd0;
                end else begin
                    nxt_state = S_START;
                end
            end
            S_BIT: begin
                if (w_tick) begin
                    // ACK sampled at the end of q2, SCL high for a full quarter
                    if ((r_qi == 3'd2) && (r_bit == 4'd8) && w_sda_in) begin
                        nxt_err = 1'b1;
                    end else begin
                        nxt_err = r_err;
                    end
                    if (r_qi == 3'd3) begin
                        nxt_qi = 3'd0;
                        if (r_bit != 4'd8) begin
                            nxt_shift = {r_shift[22:0], 1'b0};
                            nxt_bit   = r_bit + 4'd1;
                        end else if (r_err || (r_byte == 2'd2)) begin
                            nxt_state = S_STOP;
                        end else begin
                            nxt_byte = r_byte + 2'd1;
                            nxt_bit  = 4'd0;
                        end
                    end else begin
                        nxt_qi = r_qi + 3'd1;
                    end
                end else begin
                    nxt_state = S_BIT;
                end
            end
            S_STOP: begin
                if (w_tick && (r_qi == 3'd4)) begin
                    nxt_state = S_DONE;
                    nxt_qi    = 3'd0;
                end else begin
                    nxt_state = S_STOP;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
                nxt_qcnt  = '0;
                nxt_qi    = 3'd0;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_qcnt  = '0;
                nxt_qi    = 3'd0;
            end
        endcase
        nxt_scl     = f_scl(nxt_state, nxt_qi);
        nxt_sda_low = f_sda_low(nxt_state, nxt_qi, nxt_bit, nxt_shift[23]);
        nxt_done    = (nxt_state == S_DONE);
    end

    // State, counters and registered bus/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_qcnt    <= '0;
            r_qi      <= 3'd0;
            r_bit     <= 4'd0;
            r_byte    <= 2'd0;
            r_shift   <= 24'd0;
            r_err     <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= nxt_state;
            r_qcnt    <= nxt_qcnt;
            r_qi      <= nxt_qi;
            r_bit     <= nxt_bit;
            r_byte    <= nxt_byte;
            r_shift   <= nxt_shift;
            r_err     <= nxt_err;
            r_scl     <= nxt_scl;
            r_sda_low <= nxt_sda_low;
            r_done    <= nxt_done;
        end
    end

endmodule

// File: tb/tb_i2c_codec_wr_master.sv
// Bench for i2c_codec_wr_master: table of transactions driven against a
// bus monitor / slave model that captures bytes on SCL rises, answers
// ACK/NACK per byte and flags protocol violations.
module tb_i2c_codec_wr_master;

    logic        clk;
    logic        rst_n;
    logic [15:0] data16;
    logic        wrt;
    logic        done;
    logic        err;
    logic        scl_w;
    wire         sda_w;

    logic        slave_low;
    logic [2:0]  nack_mask;

    pullup (sda_w);
    assign sda_w = slave_low ? 1'b0 : 1'bz;

    i2c_codec_wr_master #(.DEV_ADDR(7'h1A), .QTR(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data16 (data16),
        .wrt    (wrt),
        .done   (done),
        .err    (err),
        .SCL    (scl_w),
        .SDA    (sda_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus monitor and slave model ----------------
    logic       prev_scl, prev_sda, mb_busy;
    logic [3:0] mb_bitpos;
    logic [1:0] mb_byte;
    logic [7:0] mb_sh;
    int         start_cnt, stop_cnt, viol;
    logic [7:0] cap[$];

    initial begin
        start_cnt = 0; stop_cnt = 0; viol = 0;
    end

    // Watch SCL/SDA each negedge: START/STOP, bit capture, slave ACK drive
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_scl  <= 1'b1;
            prev_sda  <= 1'b1;
            mb_busy   <= 1'b0;
            mb_bitpos <= 4'd0;
            mb_byte   <= 2'd0;
            slave_low <= 1'b0;
        end else begin
            prev_scl <= scl_w;
            prev_sda <= sda_w;
            if ((sda_w !== 1'b0) && (sda_w !== 1'b1)) viol <= viol + 1;
            if (scl_w && prev_scl && (sda_w != prev_sda)) begin
                if (!sda_w) begin
                    if (mb_busy) viol <= viol + 1;
                    else begin
                        start_cnt <= start_cnt + 1;
                        mb_busy   <= 1'b1;
                        mb_bitpos <= 4'd0;
                        mb_byte   <= 2'd0;
                    end
                end else begin
                    if (!mb_busy) viol <= viol + 1;
                    else begin
                        stop_cnt <= stop_cnt + 1;
                        mb_busy  <= 1'b0;
                    end
                end
            end else if (scl_w && !prev_scl) begin
                if (!mb_busy) viol <= viol + 1;
                else if (mb_bitpos < 4'd8) begin
                    mb_sh <= {mb_sh[6:0], sda_w};
                    if (mb_bitpos == 4'd7) cap.push_back({mb_sh[6:0], sda_w});
                    mb_bitpos <= mb_bitpos + 4'd1;
                end else if (mb_bitpos == 4'd8) begin
                    mb_bitpos <= 4'd9;
                end
            end else if (!scl_w && prev_scl && mb_busy) begin
                if (mb_bitpos == 4'd8) begin
                    slave_low <= ~nack_mask[mb_byte];
                end else if (mb_bitpos == 4'd9) begin
                    slave_low <= 1'b0;
                    mb_bitpos <= 4'd0;
                    if (mb_byte != 2'd3) mb_byte <= mb_byte + 2'd1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int tests, fails;

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    typedef struct {
        logic [15:0] data;
        logic [2:0]  mask;       // bit i set -> slave NACKs byte i
        int          exp_cyc;    // cycle of the done pulse (wrt cycle = 0)
        logic        exp_err;
        int          err_cyc;    // first cycle err must read 1 (0 = never)
        int          nb;         // bytes expected on the bus
        logic [7:0]  b0, b1, b2;
        int          stray_a, stray_b;  // cycles with an extra wrt pulse
        int          rst_at;     // cycle to pull rst_n low (0 = none)
    } vec_t;

    vec_t vecs[8];

    task automatic run_txn(input int idx, input vec_t v);
        int base_cap, s0, p0, v0, done_cnt, done_cyc;
        logic err_at_done;
        logic [7:0] exp_b[3];
        logic aborted;
        base_cap = cap.size(); s0 = start_cnt; p0 = stop_cnt; v0 = viol;
        done_cnt = 0; done_cyc = 0; err_at_done = 1'b0; aborted = 1'b0;
        exp_b[0] = v.b0; exp_b[1] = v.b1; exp_b[2] = v.b2;
        nack_mask = v.mask;
        @(negedge clk);
        data16 = v.data; wrt = 1'b1;
        @(posedge clk); #1;
        wrt = 1'b0; data16 = 16'h0000;
        check("err_clear_on_accept", idx, {31'd0, err}, 32'd0);
        for (int cyc = 1; cyc <= 2100; cyc++) begin
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) begin done_cyc = cyc; err_at_done = err; end
            end
            if (v.err_cyc != 0 && cyc == v.err_cyc - 1) check("err_before_ack", idx, {31'd0, err}, 32'd0);
            if (v.err_cyc != 0 && cyc == v.err_cyc)     check("err_at_ack", idx, {31'd0, err}, 32'd1);
            if (v.rst_at != 0 && cyc == v.rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_scl", idx, {31'd0, scl_w}, 32'd1);
                check("rst_sda", idx, {31'd0, sda_w}, 32'd1);
                check("rst_done", idx, {31'd0, done}, 32'd0);
                check("rst_err", idx, {31'd0, err}, 32'd0);
                @(negedge clk); @(negedge clk);
                rst_n = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (cyc == v.stray_a || cyc == v.stray_b) begin
                wrt = 1'b1; data16 = 16'hFFFF;
            end else begin
                wrt = 1'b0; data16 = 16'h0000;
            end
            if (done_cyc != 0 && cyc >= done_cyc + 40) break;
            @(posedge clk); #1;
        end
        wrt = 1'b0;
        if (!aborted) begin
            if (done_cyc == 0) begin
                tests++; fails++;
                $display("FAIL done_timeout (vec %0d): no done within 2100 cycles", idx);
            end else begin
                check("done_cycle", idx, done_cyc, v.exp_cyc);
            end
            check("done_pulses", idx, done_cnt, 32'd1);
            check("err_at_done", idx, {31'd0, err_at_done}, {31'd0, v.exp_err});
            check("err_held_idle", idx, {31'd0, err}, {31'd0, v.exp_err});
            check("bus_idle_scl", idx, {31'd0, scl_w}, 32'd1);
            check("start_count", idx, start_cnt - s0, 32'd1);
            check("stop_count", idx, stop_cnt - p0, 32'd1);
            check("byte_count", idx, cap.size() - base_cap, v.nb);
            for (int i = 0; i < v.nb; i++) begin
                if (base_cap + i < cap.size())
                    check("bus_byte", idx, {24'd0, cap[base_cap + i]}, {24'd0, exp_b[i]});
            end
        end
        check("protocol_violations", idx, viol - v0, 32'd0);
    endtask

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; wrt = 1'b0; data16 = 16'h0000; nack_mask = 3'b000;
        //          data      mask    cyc  err  errcyc nb  b0     b1     b2     sa    sb    rst
        vecs[0] = '{16'h0C62, 3'b000, 1841, 1'b0, 0,    3, 8'h34, 8'h0C, 8'h62, 0,    0,    0};
        vecs[1] = '{16'h0105, 3'b001, 689,  1'b1, 593,  1, 8'h34, 8'h00, 8'h00, 0,    0,    0};
        vecs[2] = '{16'h1201, 3'b000, 1841, 1'b0, 0,    3, 8'h34, 8'h12, 8'h01, 0,    0,    0};
        vecs[3] = '{16'h0C62, 3'b100, 1841, 1'b1, 1745, 3, 8'h34, 8'h0C, 8'h62, 0,    0,    0};
        vecs[4] = '{16'h0812, 3'b000, 1841, 1'b0, 0,    3, 8'h34, 8'h08, 8'h12, 10,   1000, 0};
        vecs[5] = '{16'h0812, 3'b000, 1841, 1'b0, 0,    3, 8'h34, 8'h08, 8'h12, 0,    0,    500};
        vecs[6] = '{16'h1201, 3'b000, 1841, 1'b0, 0,    3, 8'h34, 8'h12, 8'h01, 0,    0,    0};
        vecs[7] = '{16'hABCD, 3'b000, 1841, 1'b0, 0,    3, 8'h34, 8'hAB, 8'hCD, 1841, 0,    0};

        repeat (3) @(negedge clk);
        check("reset_scl", 0, {31'd0, scl_w}, 32'd1);
        check("reset_sda", 0, {31'd0, sda_w}, 32'd1);
        check("reset_done", 0, {31'd0, done}, 32'd0);
        check("reset_err", 0, {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_txn(i, vecs[i]);
            repeat (4) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
